// File: rtl/tlul_sram_slave.sv
// tlul_sram_slave: TL-UL slave with a word-addressed SRAM, one outstanding request, fixed response latency.
//   Ports: clk_24/reset (sync, active-low); slave_a_* request channel in (ready out);
//   slave_d_* response channel out (ready in); slave_d_error flags an illegal request.
module tlul_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH = 3,
  parameter int MEM_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int RESP_LATENCY = 1
) (
  input  logic                    clk_24,
  input  logic                    reset,
  input  logic                    slave_a_valid,
  output logic                    slave_a_ready,
  input  logic [OPCODE_WIDTH-1:0] slave_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  slave_a_param,
  input  logic [SIZE_WIDTH-1:0]   slave_a_size,
  input  logic                    slave_a_source,
  input  logic [ADDR_WIDTH-1:0]   slave_a_address,
  input  logic [MASK_WIDTH-1:0]   slave_a_mask,
  input  logic [DATA_WIDTH-1:0]   slave_a_data,
  output logic                    slave_d_valid,
  input  logic                    slave_d_ready,
  output logic [OPCODE_WIDTH-1:0] slave_d_opcode,
  output logic [PARAM_WIDTH-1:0]  slave_d_param,
  output logic [SIZE_WIDTH-1:0]   slave_d_size,
  output logic                    slave_d_source,
  output logic                    slave_d_sink,
  output logic [DATA_WIDTH-1:0]   slave_d_data,
  output logic                    slave_d_error
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
  logic [SIZE_WIDTH-1:0] d_size_q, d_size_d;
  logic d_source_q, d_source_d, d_error_q, d_error_d;
  logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] off;
  logic [IW-1:0] idx;
  logic [MASK_WIDTH-1:0] full_mask;
  logic a_fire, is_get, is_put, err;
  always_comb begin
    off = slave_a_address - BASE_ADDR;
    idx = off[IW+1:2];
    is_get = slave_a_opcode == OPCODE_WIDTH'(4);
    is_put = slave_a_opcode == OPCODE_WIDTH'(0) || slave_a_opcode == OPCODE_WIDTH'(1);
    full_mask = (slave_a_size == SIZE_WIDTH'(0) ? 4'h1 : slave_a_size == SIZE_WIDTH'(1) ? 4'h3 : 4'hf) << slave_a_address[1:0];
    err = off >= ADDR_WIDTH'(MEM_WORDS * 4) || !(is_get || is_put) || slave_a_param != '0
       || slave_a_size > SIZE_WIDTH'(2)
       || (slave_a_size == SIZE_WIDTH'(1) && slave_a_address[0])
       || (slave_a_size == SIZE_WIDTH'(2) && slave_a_address[1:0] != 2'b00)
       || (slave_a_opcode == OPCODE_WIDTH'(0) && slave_a_mask != full_mask);
    a_fire = slave_a_valid && slave_a_ready;
    state_d = state_q;
    cnt_d = cnt_q;
    d_opcode_d = d_opcode_q;
    d_size_d = d_size_q;
    d_source_d = d_source_q;
    d_error_d = d_error_q;
    d_data_d = d_data_q;
    if (a_fire) begin
      state_d = RESP_LATENCY > 1 ? WAIT : RESP;
      cnt_d = 4'(RESP_LATENCY - 1);
      d_opcode_d = is_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
      d_size_d = slave_a_size;
      d_source_d = slave_a_source;
      d_error_d = err;
      d_data_d = is_get && !err ? mem[idx] : '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (state_q == RESP && slave_d_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_24) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      d_opcode_q <= '0;
      d_size_q <= '0;
      d_source_q <= 1'b0;
      d_error_q <= 1'b0;
      d_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d_opcode_q <= d_opcode_d;
      d_size_q <= d_size_d;
      d_source_q <= d_source_d;
      d_error_q <= d_error_d;
      d_data_q <= d_data_d;
    end
  end
  // SRAM has no reset; a_fire is already gated by reset through a_ready
  always_ff @(posedge clk_24) begin
    if (a_fire && is_put && !err)
      for (int i = 0; i < MASK_WIDTH; i++)
        if (slave_a_mask[i]) mem[idx][8*i +: 8] <= slave_a_data[8*i +: 8];
  end
  assign slave_a_ready = reset && state_q == IDLE;
  assign slave_d_valid = state_q == RESP;
  assign slave_d_opcode = d_opcode_q;
  assign slave_d_param = '0;
  assign slave_d_size = d_size_q;
  assign slave_d_source = d_source_q;
  assign slave_d_sink = 1'b0;
  assign slave_d_data = d_data_q;
  assign slave_d_error = d_error_q;
endmodule

// File: tb/tb_tlul_sram_slave.sv
// tb_tlul_sram_slave: directed table-driven bench for tlul_sram_slave with RESP_LATENCY=3.
module tb_tlul_sram_slave;
  logic clk_24 = 1'b0;
  logic reset = 1'b0;
  logic a_valid = 1'b0, a_ready, a_source = 1'b0;
  logic [2:0] a_opcode = '0, a_param = '0, a_size = '0;
  logic [31:0] a_address = '0, a_data = '0;
  logic [3:0] a_mask = '0;
  logic d_valid, d_ready = 1'b1, d_source, d_sink, d_error;
  logic [2:0] d_opcode, d_param, d_size;
  logic [31:0] d_data;
  int n_cmp = 0, n_fail = 0;
  always #5 clk_24 = ~clk_24;
  tlul_sram_slave #(.RESP_LATENCY(3)) dut (
    .clk_24(clk_24), .reset(reset),
    .slave_a_valid(a_valid), .slave_a_ready(a_ready), .slave_a_opcode(a_opcode),
    .slave_a_param(a_param), .slave_a_size(a_size), .slave_a_source(a_source),
    .slave_a_address(a_address), .slave_a_mask(a_mask), .slave_a_data(a_data),
    .slave_d_valid(d_valid), .slave_d_ready(d_ready), .slave_d_opcode(d_opcode),
    .slave_d_param(d_param), .slave_d_size(d_size), .slave_d_source(d_source),
    .slave_d_sink(d_sink), .slave_d_data(d_data), .slave_d_error(d_error)
  );
  typedef struct packed {
    logic [2:0] op, par, sz;
    logic src;
    logic [31:0] addr;
    logic [3:0] mask;
    logic [31:0] data;
    logic [2:0] eop;
    logic [31:0] edata;
    logic eerr;
  } vec_t;
  vec_t v [23];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input vec_t r, input string name);
    @(negedge clk_24);
    a_opcode = r.op; a_param = r.par; a_size = r.sz; a_source = r.src;
    a_address = r.addr; a_mask = r.mask; a_data = r.data; a_valid = 1'b1;
    chk({name, " a_ready idle"}, 64'(a_ready), 64'd1);
    @(posedge clk_24);
    #1 a_valid = 1'b0;
  endtask
  task automatic wait_dv(input string name, output int lat);
    lat = 0;
    while (!d_valid && lat < 20) begin
      @(posedge clk_24);
      #1 lat++;
    end
    if (!d_valid) chk({name, " d_valid timeout"}, 64'(d_valid), 64'd1);
  endtask
  task automatic fire_d(input string name);
    @(posedge clk_24);
    #1;
    chk({name, " d_valid after fire"}, 64'(d_valid), 64'd0);
    chk({name, " a_ready after fire"}, 64'(a_ready), 64'd1);
  endtask
  task automatic run(input vec_t r, input string name);
    int lat;
    issue(r, name);
    wait_dv(name, lat);
    chk({name, " latency"}, 64'(lat), 64'd2);
    chk({name, " opcode"}, 64'(d_opcode), 64'(r.eop));
    chk({name, " size"}, 64'(d_size), 64'(r.sz));
    chk({name, " source"}, 64'(d_source), 64'(r.src));
    chk({name, " data"}, 64'(d_data), 64'(r.edata));
    chk({name, " error"}, 64'(d_error), 64'(r.eerr));
    chk({name, " param/sink"}, {d_param, d_sink}, 64'd0);
    fire_d(name);
  endtask
  initial begin
    logic [63:0] snap;
    int lat;
    v[0]  = '{3'd0, 3'd0, 3'd2, 1'b0, 32'h10, 4'hf, 32'hDEADBEEF, 3'd0, 32'h0, 1'b0};
    v[1]  = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h10, 4'hf, 32'h0, 3'd1, 32'hDEADBEEF, 1'b0};
    v[2]  = '{3'd0, 3'd0, 3'd2, 1'b0, 32'h20, 4'hf, 32'h11223344, 3'd0, 32'h0, 1'b0};
    v[3]  = '{3'd1, 3'd0, 3'd2, 1'b1, 32'h20, 4'h6, 32'hAABBCCDD, 3'd0, 32'h0, 1'b0};
    v[4]  = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h20, 4'hf, 32'h0, 3'd1, 32'h11BBCC44, 1'b0};
    v[5]  = '{3'd0, 3'd0, 3'd2, 1'b0, 32'h0, 4'hf, 32'h55667788, 3'd0, 32'h0, 1'b0};
    v[6]  = '{3'd0, 3'd0, 3'd2, 1'b1, 32'h2, 4'hf, 32'hFFFFFFFF, 3'd0, 32'h0, 1'b1};
    v[7]  = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h0, 4'hf, 32'h0, 3'd1, 32'h55667788, 1'b0};
    v[8]  = '{3'd4, 3'd0, 3'd2, 1'b1, 32'h400, 4'hf, 32'h0, 3'd1, 32'h0, 1'b1};
    v[9]  = '{3'd4, 3'd1, 3'd2, 1'b0, 32'h10, 4'hf, 32'h0, 3'd1, 32'h0, 1'b1};
    v[10] = '{3'd2, 3'd0, 3'd2, 1'b1, 32'h10, 4'hf, 32'h0, 3'd0, 32'h0, 1'b1};
    v[11] = '{3'd4, 3'd0, 3'd3, 1'b0, 32'h10, 4'hf, 32'h0, 3'd1, 32'h0, 1'b1};
    v[12] = '{3'd4, 3'd0, 3'd1, 1'b0, 32'h11, 4'h3, 32'h0, 3'd1, 32'h0, 1'b1};
    v[13] = '{3'd0, 3'd0, 3'd0, 1'b0, 32'h13, 4'h8, 32'h99000000, 3'd0, 32'h0, 1'b0};
    v[14] = '{3'd0, 3'd0, 3'd1, 1'b0, 32'h12, 4'h4, 32'h12345678, 3'd0, 32'h0, 1'b1};
    v[15] = '{3'd4, 3'd0, 3'd2, 1'b1, 32'h10, 4'hf, 32'h0, 3'd1, 32'h99ADBEEF, 1'b0};
    v[16] = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h20, 4'hf, 32'h0, 3'd1, 32'h11BBCC44, 1'b0};
    v[17] = '{3'd0, 3'd0, 3'd2, 1'b0, 32'h3FC, 4'hf, 32'h0BADF00D, 3'd0, 32'h0, 1'b0};
    v[18] = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h3FC, 4'hf, 32'h0, 3'd1, 32'h0BADF00D, 1'b0};
    v[19] = '{3'd4, 3'd0, 3'd2, 1'b0, 32'hFFFFFFFC, 4'hf, 32'h0, 3'd1, 32'h0, 1'b1};
    v[20] = '{3'd1, 3'd0, 3'd2, 1'b0, 32'h400, 4'hf, 32'h00000001, 3'd0, 32'h0, 1'b1};
    v[21] = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h0, 4'hf, 32'h0, 3'd1, 32'h55667788, 1'b0};
    v[22] = '{3'd4, 3'd0, 3'd2, 1'b0, 32'h20, 4'h0, 32'h0, 3'd1, 32'h11BBCC44, 1'b0};
    repeat (3) @(posedge clk_24);
    #1;
    chk("reset a_ready", 64'(a_ready), 64'd0);
    chk("reset d_valid", 64'(d_valid), 64'd0);
    chk("reset d_fields", {d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data}, 64'd0);
    @(negedge clk_24) reset = 1'b1;
    @(posedge clk_24);
    #1 chk("release a_ready", 64'(a_ready), 64'd1);
    for (int i = 0; i < 23; i++) run(v[i], $sformatf("vec%0d", i));
    d_ready = 1'b0;
    issue('{3'd4, 3'd0, 3'd2, 1'b1, 32'h20, 4'hf, 32'h0, 3'd0, 32'h0, 1'b0}, "bp");
    wait_dv("bp", lat);
    chk("bp latency", 64'(lat), 64'd2);
    chk("bp data", 64'(d_data), 64'h11BBCC44);
    snap = {d_opcode, d_size, d_source, d_error, d_data};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_24);
      a_opcode = 3'd0; a_size = 3'd2; a_address = 32'h20; a_mask = 4'hf; a_data = 32'h0; a_valid = 1'b1;
      @(posedge clk_24);
      #1;
      chk($sformatf("bp%0d a_ready", k), 64'(a_ready), 64'd0);
      chk($sformatf("bp%0d d_valid", k), 64'(d_valid), 64'd1);
      chk($sformatf("bp%0d hold", k), {d_opcode, d_size, d_source, d_error, d_data}, snap);
    end
    @(negedge clk_24);
    a_valid = 1'b0;
    d_ready = 1'b1;
    fire_d("bp");
    run(v[16], "bp_ignored_put");
    run('{3'd4, 3'd0, 3'd2, 1'b1, 32'h10, 4'hf, 32'h0, 3'd1, 32'h99ADBEEF, 1'b0}, "b2b_src1");
    run('{3'd4, 3'd0, 3'd2, 1'b0, 32'h20, 4'hf, 32'h0, 3'd1, 32'h11BBCC44, 1'b0}, "b2b_src0");
    d_ready = 1'b0;
    issue('{3'd0, 3'd0, 3'd2, 1'b0, 32'h30, 4'hf, 32'hCAFEF00D, 3'd0, 32'h0, 1'b0}, "rst");
    wait_dv("rst", lat);
    @(negedge clk_24) reset = 1'b0;
    @(posedge clk_24);
    #1;
    chk("rst d_valid", 64'(d_valid), 64'd0);
    chk("rst a_ready held", 64'(a_ready), 64'd0);
    @(negedge clk_24);
    reset = 1'b1;
    d_ready = 1'b1;
    @(posedge clk_24);
    #1 chk("rst a_ready", 64'(a_ready), 64'd1);
    run('{3'd4, 3'd0, 3'd2, 1'b0, 32'h30, 4'hf, 32'h0, 3'd1, 32'hCAFEF00D, 1'b0}, "rst_get");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tlul_sram_slave.md
# tlul_sram_slave

TL-UL slave memory model that sits directly downstream of the 1-master/1-slave interconnect's slave socket. It consumes Channel A requests (Get, PutFullData, PutPartialData), services them from an internal word-addressed SRAM, and returns Channel D responses (AccessAck, AccessAckData) after a programmable latency. It handles one outstanding transaction at a time, applies byte masks on writes, and flags illegal requests with `d_error`. It is the default slave for interconnect bring-up and for monitor-driven regression.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits; only 32 is supported.
- `ADDR_WIDTH`, 32: address width.
- `MASK_WIDTH`, DATA_WIDTH/8: byte-mask width.
- `SIZE_WIDTH`, 3: `size` field width, encoded as log2 bytes.
- `OPCODE_WIDTH`, 3: opcode width.
- `PARAM_WIDTH`, 3: param width.
- `MEM_WORDS`, 256: SRAM depth in 32-bit words; must be a power of 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to MEM_WORDS*4.
- `RESP_LATENCY`, 1: cycles from the A accept edge to `d_valid` rising; legal range 1..15.

Ports:
- `clk_24`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low reset.
- `slave_a_valid`, in, 1: A request valid.
- `slave_a_ready`, out, 1: A request ready.
- `slave_a_opcode`, in, OPCODE_WIDTH: 0=PutFullData, 1=PutPartialData, 4=Get.
- `slave_a_param`, in, PARAM_WIDTH: must be 0.
- `slave_a_size`, in, SIZE_WIDTH: transfer size, log2 bytes.
- `slave_a_source`, in, 1: source ID.
- `slave_a_address`, in, ADDR_WIDTH: byte address.
- `slave_a_mask`, in, MASK_WIDTH: byte lanes.
- `slave_a_data`, in, DATA_WIDTH: write data.
- `slave_d_valid`, out, 1: D response valid.
- `slave_d_ready`, in, 1: D response ready.
- `slave_d_opcode`, out, OPCODE_WIDTH: 0=AccessAck, 1=AccessAckData.
- `slave_d_param`, out, PARAM_WIDTH: always 0.
- `slave_d_size`, out, SIZE_WIDTH: echo of the request size.
- `slave_d_source`, out, 1: echo of the request source.
- `slave_d_sink`, out, 1: always 0.
- `slave_d_data`, out, DATA_WIDTH: read data.
- `slave_d_error`, out, 1: request was illegal.

## Operation
- FSM states are IDLE, WAIT and RESP.
  - IDLE: `slave_a_ready`=1. The A fire (`valid&&ready`) latches opcode, size and source, evaluates legality, and performs the access. Next state is WAIT if RESP_LATENCY>1, otherwise RESP.
  - WAIT: a down-counter is loaded with RESP_LATENCY-1 at accept. Enter RESP when the counter reaches 1.
  - RESP: `slave_d_valid`=1. On `slave_d_ready`=1, go to IDLE.
- Legality: the request is an error if any of the following holds. In that case no memory write occurs.
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4);
  - opcode not in {0,1,4};
  - param≠0;
  - size>2;
  - address not aligned to 2^size;
  - PutFullData mask ≠ the contiguous lanes implied by size and address[1:0].
- Word index = (address−BASE_ADDR)[$clog2(MEM_WORDS)+1:2].
- Put (legal): write each byte lane i where `mask[i]`=1, at the accept edge. The response is AccessAck with data 0.
- Get (legal): read the full word at the accept edge into a response register. The response is AccessAckData. The full word is returned regardless of mask.
- Error response:
  - `d_error`=1 and `d_data`=0.
  - Opcode is AccessAckData for Get and AccessAck otherwise, including invalid opcodes.
  - size and source are echoed.
- SRAM contents are not cleared by reset; they are undefined until written.

## Timing
- All D outputs are registered and held stable from `d_valid` rising until the D fire.
- Reset values: `slave_a_ready`=0 during reset and 1 on the first cycle after reset deasserts. `slave_d_valid`=0, and opcode, param, size, source, sink, data and error are all 0.
- Latency: with the A fire at edge N, `d_valid` is first high in the cycle after edge N+RESP_LATENCY−1. With RESP_LATENCY=1, `d_valid` is high in the cycle immediately after the accept.
- `slave_a_ready`=0 in WAIT and RESP. After the D fire, `a_ready` returns to 1 in the next cycle, so an A and a D fire never occur in the same cycle. Peak throughput is one transaction per RESP_LATENCY+1 cycles.
- D backpressure: RESP holds indefinitely while `d_ready`=0, with no output change.
- Write visibility: a Get accepted after a Put's D fire returns the new data.
- Reset mid-operation: the pending response is discarded and the FSM returns to IDLE. A write committed at accept is retained.
- `slave_a_*` inputs are ignored when `a_ready`=0.

## Test plan
- Put then Get: PutFullData addr 0x10, size 2, mask 0xF, data 0xDEADBEEF, then Get 0x10 -> AccessAck with error 0, then AccessAckData with data 0xDEADBEEF and size 2 echoed.
- Partial write: a word holding 0x11223344, then PutPartialData with mask 0x6 and data 0xAABBCCDD, then Get -> 0x11BBCC44.
- Errors:
  - Get at BASE_ADDR+0x400 (MEM_WORDS=256) -> d_error 1, data 0, opcode 1.
  - PutFullData size 2 at 0x2 -> error, and a later Get at 0x0 shows memory unchanged.
- Latency and backpressure: RESP_LATENCY=3 with the accept at edge N -> d_valid rises after edge N+2. Hold d_ready low for 5 cycles -> outputs stable and a_ready=0 throughout, then a_ready=1 the cycle after the D fire.
- Source echo: back-to-back Gets with source 1 then 0 -> d_source 1 then 0, each returned one transaction at a time.
- Reset mid-response: assert reset while in RESP -> d_valid=0 after the reset edge and a_ready=1 after release. A Get then returns the data of the Put accepted before the reset.
